// File: rtl/shared_timer_arbiter.sv
// shared_timer_arbiter: round-robin sharing of one programmable down-counter
// among NUM_REQ requesters, with a one-cycle done pulse back to the owner.
module shared_timer_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0] load_val,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           done,
    output logic [CNT_WIDTH-1:0]         count,
    output logic                         busy
);
    localparam int PTR_W = $clog2(NUM_REQ);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t                 state, state_n;
    logic [PTR_W-1:0]       rr_ptr, rr_n, owner, owner_n, pick, idx;
    logic [NUM_REQ-1:0]     grant_n, done_n;
    logic [CNT_WIDTH-1:0]   count_n;
    // Scan offsets from farthest to nearest so the nearest set bit after rr_ptr wins.
    always_comb begin
        pick = rr_ptr;
        idx  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (req[idx]) pick = idx;
        end
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        done_n  = '0;
        count_n = count;
        rr_n    = rr_ptr;
        owner_n = owner;
        unique case (state)
            IDLE: if (req != '0) begin
                state_n = COUNT;
                grant_n = NUM_REQ'(1) << pick;
                count_n = load_val[int'(pick)*CNT_WIDTH +: CNT_WIDTH];
                owner_n = pick;
            end
            COUNT: if (!req[owner]) begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
                rr_n    = owner;
            end else if (count == '0) begin
                state_n = DONE;
                done_n  = grant;
            end else begin
                count_n = count - 1'b1;
            end
            DONE: begin
                state_n = IDLE;
                grant_n = '0;
                count_n = '0;
                rr_n    = owner;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            count  <= '0;
            rr_ptr <= PTR_W'(NUM_REQ - 1);
            owner  <= '0;
        end else begin
            state  <= state_n;
            grant  <= grant_n;
            done   <= done_n;
            count  <= count_n;
            rr_ptr <= rr_n;
            owner  <= owner_n;
        end
    end
    assign busy = (state != IDLE);
endmodule
